// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: walks the fetch PC, reads a 1-cycle synchronous ROM and
// buffers words in a DEPTH-entry prefetch queue. Define IF_BYPASS_EN for empty-queue bypass.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_imem_req,
  output logic [ADDR_W-1:0]        o_imem_addr,
  input  logic [31:0]              i_imem_data,
  output logic                     o_inst_valid,
  input  logic                     i_inst_ready,
  output logic [31:0]              o_inst_code,
  output logic [31:0]              o_inst_pc,
  output logic [31:0]              o_inst_pc_new,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic [$clog2(DEPTH):0]   o_q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      r_fpc;
  logic [31:0]      r_ipc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_last_code;
  logic [31:0]      r_last_pc;
  logic [31:0]      r_q_code [DEPTH];
  logic [31:0]      r_q_pc   [DEPTH];

  logic             w_bypass;
  logic             w_q_nonempty;
  logic             w_pop;
  logic             w_qpop;
  logic             w_push;
  logic             w_issue;
  logic [OCC_W-1:0] w_occ;
  logic             w_unused;

  assign w_unused     = ^i_redirect_pc[1:0];
  assign w_q_nonempty = (r_count != '0);

`ifdef IF_BYPASS_EN
  // A returning word is presented directly when nothing older is queued.
  assign w_bypass = r_inflight && !w_q_nonempty;

  always_comb begin
    o_inst_code = r_last_code;
    o_inst_pc   = r_last_pc;
    if (w_q_nonempty) begin
      o_inst_code = r_q_code[r_rd_ptr];
      o_inst_pc   = r_q_pc[r_rd_ptr];
    end else if (w_bypass) begin
      o_inst_code = i_imem_data;
      o_inst_pc   = r_ipc;
    end
  end
`else
  assign w_bypass = 1'b0;

  always_comb begin
    o_inst_code = r_last_code;
    o_inst_pc   = r_last_pc;
    if (w_q_nonempty) begin
      o_inst_code = r_q_code[r_rd_ptr];
      o_inst_pc   = r_q_pc[r_rd_ptr];
    end
  end
`endif

  assign o_inst_valid  = w_q_nonempty || w_bypass;
  assign o_inst_pc_new = o_inst_pc + 32'd4;
  assign o_q_count     = r_count;
  assign o_imem_addr   = r_fpc[ADDR_W+1:2];

  assign w_pop  = o_inst_valid && i_inst_ready;
  assign w_qpop = w_pop && w_q_nonempty;
  // A bypassed word that is consumed immediately never occupies a slot.
  assign w_push = r_inflight && !i_redirect && !(w_bypass && w_pop);

  // Slots committed after this cycle: queued + returning - leaving.
  assign w_occ   = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue = !i_rst && !i_redirect && (w_occ < OCC_W'(DEPTH));
  assign o_imem_req = w_issue;

  // Fetch PC, in-flight tracking, queue pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fpc       <= RESET_PC;
      r_ipc       <= 32'h0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_last_code <= 32'h0;
      r_last_pc   <= 32'h0;
    end else begin
      r_inflight <= w_issue;
      if (w_pop) begin
        r_last_code <= o_inst_code;
        r_last_pc   <= o_inst_pc;
      end
      if (w_issue) begin
        r_ipc <= r_fpc;
        r_fpc <= r_fpc + 32'd4;
      end
      if (i_redirect) begin
        r_fpc    <= {i_redirect_pc[31:2], 2'b00};
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_qpop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_qpop);
      end
    end
  end

  // Queue storage; contents are meaningful only between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_code[r_wr_ptr] <= i_imem_data;
      r_q_pc[r_wr_ptr]   <= r_ipc;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: ROM[i] = 32'h1000_0000 + i, expected words queued
// by the stimulus and compared by an independent monitor on every accepted instruction.
module tb_if_prefetch_unit;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
  } exp_t;

`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_new;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   ok;

  if_prefetch_unit #(.DEPTH(4), .ADDR_W(6), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst_code(inst_code), .o_inst_pc(inst_pc), .o_inst_pc_new(inst_pc_new),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_range(input logic [31:0] first_pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = first_pc + 32'(4 * i);
      e.code = 32'h1000_0000 + ((e.pc >> 2) & 32'h3f);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_head(input logic [31:0] pc, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #1;
      if (inst_valid && inst_pc == pc) found = 1'b1;
    end
  endtask

  // Monitor: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected word pc", inst_pc, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("word code", inst_code, e.code);
        chk("word pc", inst_pc, e.pc);
        chk("word pc_new", inst_pc_new, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("reset valid", 32'(inst_valid), 32'd0);
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset count", 32'(q_count), 32'd0);
    chk("reset code", inst_code, 32'h0);
    chk("reset pc", inst_pc, 32'h0);
    chk("reset pc_new", inst_pc_new, 32'h4);

    // Streaming from RESET_PC with decode always ready
    push_range(32'h0, 30);
    @(negedge clk); rst = 1'b0;
    #3;
    chk("c0 req", 32'(imem_req), 32'd1);
    chk("c0 valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #3;
    chk("c1 valid", 32'(inst_valid), 32'(BYP));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #3;
      chk("stream valid", 32'(inst_valid), 32'd1);
      chk("stream count", 32'(q_count), BYP ? 32'd0 : 32'd1);
    end

    // Asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(inst_valid), 32'd0);
    chk("async rst count", 32'(q_count), 32'd0);
    chk("async rst req", 32'(imem_req), 32'd0);
    exp_q.delete();

    // Backpressure: queue fills, fetch stalls, head holds ROM[0]
    inst_ready = 1'b0;
    push_range(32'h0, 7);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    chk("full count", 32'(q_count), 32'd4);
    chk("full req", 32'(imem_req), 32'd0);
    chk("full valid", 32'(inst_valid), 32'd1);
    chk("full head code", inst_code, 32'h1000_0000);
    chk("full head pc", inst_pc, 32'h0);
    @(negedge clk); inst_ready = 1'b1;

    // Redirect to 0x20 while w6 is popped, w7/w8 queued and w9 in flight
    wait_head(32'h18, ok);
    chk("head 0x18 seen", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h20;
    #2;
    chk("redir req", 32'(imem_req), 32'd0);
    chk("redir pre count", 32'(q_count), 32'd3);
    chk("words 0..6 drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    push_range(32'h20, 8);
    @(negedge clk); redirect = 1'b0;
    #3;
    chk("R+1 req", 32'(imem_req), 32'd1);
    chk("R+1 valid", 32'(inst_valid), 32'd0);
    chk("R+1 count", 32'(q_count), 32'd0);
    @(negedge clk); #3;
    chk("R+2 valid", 32'(inst_valid), 32'(BYP));
    @(negedge clk); #3;
    chk("R+3 valid", 32'(inst_valid), 32'd1);

    // Misaligned redirect target is forced to a word boundary
    wait_head(32'h28, ok);
    chk("head 0x28 seen", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h23;
    #2;
    exp_q.delete();
    push_range(32'h20, 8);
    @(negedge clk); redirect = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk); #3;
      if (exp_q.size() <= 3) ok = 1'b1;
    end
    chk("post-redirect words drained", 32'(ok), 32'd1);

    // Reset again mid-stream, then confirm fetch restarts at RESET_PC
    rst = 1'b1;
    #1;
    chk("async rst2 valid", 32'(inst_valid), 32'd0);
    chk("async rst2 count", 32'(q_count), 32'd0);
    exp_q.delete();
    inst_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("restart valid", 32'(inst_valid), 32'd1);
    chk("restart pc", inst_pc, 32'h0);
    chk("restart code", inst_code, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
